ram_b_arbiter: RTL
==================

# ram_b_arbiter

Controller for port B of the shared 1024×16 data RAM, which the CPU does not use. After reset it optionally sweeps the whole RAM to zero. It then arbitrates port B between two requesters (e.g. a display scanner and a debug/loader) using a valid/ready handshake and round-robin priority. Read data returns on a fixed one-cycle-latency response channel. It sits beside the CPU, RAM and ROM in the top level and owns address_b, data_b, wren_b and q_b of the RAM instance.

## Interface
Parameters:
- DATA_WIDTH, 16, RAM word width
- RAM_REGISTER_COUNT, 1024, RAM depth; a power of two ≥ 2; AW = $clog2(RAM_REGISTER_COUNT)

Ports:
- Clk  in  1  single clock; all logic on its rising edge
- Reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester i has a request
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  word address
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data
- req0_ready / req1_ready  out  1  grant; request accepted when valid && ready in the same cycle
- req0_rvalid / req1_rvalid  out  1  read data valid for requester i
- req0_rdata / req1_rdata  out  DATA_WIDTH  read data; equals ram_q_b when rvalid = 1, otherwise 0
- ram_address_b  out  AW  to RAM address_b
- ram_data_b  out  DATA_WIDTH  to RAM data_b
- ram_wren_b  out  1  to RAM wren_b
- ram_q_b  in  DATA_WIDTH  from RAM q_b; valid one cycle after the address is presented
- clear_busy  out  1  RAM clear sweep in progress

## Operation
- States: CLEAR and SERVE. Reset enters CLEAR when RAM_CLEAR_EN is defined, otherwise SERVE.
- CLEAR:
  - clr_cnt (AW bits) starts at 0.
  - Each cycle drives ram_address_b = clr_cnt, ram_data_b = 0, ram_wren_b = 1, then increments clr_cnt.
  - After the write to RAM_REGISTER_COUNT-1, the next cycle is SERVE.
  - Both readys are 0 and clear_busy = 1 throughout.
- SERVE arbitration, combinational within the cycle:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester selected by prio (1 bit, reset value 0 = req0).
  - Neither valid: no grant.
- On any grant to i, prio becomes the other requester in the next cycle. When idle, prio holds.
- The granted requester's addr, wdata and we drive ram_address_b, ram_data_b and ram_wren_b in the same cycle.
- With no grant: ram_wren_b = 0, ram_address_b = 0, ram_data_b = 0.
- Granted read: rvalid for that requester is registered to 1 in the next cycle. rdata is ram_q_b in that cycle.
- Granted write: no response.
- Requesters must hold valid, addr, we and wdata stable until ready. The arbiter never revokes a grant within a cycle.
- Every SERVE cycle can accept a request; back-to-back reads give back-to-back rvalids.

## Timing
- Reset values, i.e. the values while Reset is high:
  - ram_wren_b = 0, ram_address_b = 0, ram_data_b = 0
  - readys = 0, rvalids = 0, rdatas = 0
  - prio = 0
  - clear_busy = 1 with RAM_CLEAR_EN, 0 without
- First cycle after Reset falls:
  - With RAM_CLEAR_EN: writes address 0.
  - Without it: SERVE, and a grant is possible.
- CLEAR lasts exactly RAM_REGISTER_COUNT cycles. The first possible grant is cycle RAM_REGISTER_COUNT after Reset falls (cycle 1024 by default).
- Read latency: accept at cycle N gives rvalid at cycle N+1. Fixed and not stallable.
- clr_cnt wrap: the last clear address is RAM_REGISTER_COUNT-1, and the counter is not used after wrap.
- Reset mid-operation, whether in CLEAR or SERVE:
  - Any pending rvalid is dropped; it reads 0 in the next cycle.
  - The clear restarts from address 0 and prio returns to 0.
- A requester that drops valid before ready has no side effects.

## Configuration
- RAM_CLEAR_EN defined:
  - CLEAR state and clr_cnt are compiled in.
  - After every reset the RAM is zero-filled before any grant.
- RAM_CLEAR_EN undefined:
  - No CLEAR state, clr_cnt or sweep logic.
  - clear_busy is tied to 0.
  - SERVE starts on the first cycle after reset, and RAM contents persist across reset.

## Test plan
- Reset sweep (RAM_CLEAR_EN): preload RAM addresses 5 and 1023 with 16'hBEEF, pulse Reset one cycle -> clear_busy high for 1024 cycles, ram_wren_b = 1 with ascending addresses 0..1023 and data 0; req0 reads of 5 and 1023 then return 16'h0000.
- Single requester: req1 writes 16'h1234 to address 10, then reads address 10 -> req1_ready in each request cycle; req1_rvalid exactly one cycle after the read accept with req1_rdata = 16'h1234; req0_rvalid stays 0.
- Contention: both requesters hold reads of addresses 1 and 2 for 4 cycles after reset -> grants go 0,1,0,1; rvalids alternate starting with req0 one cycle later.
- Back-to-back reads: req0 streams addresses 0..7 with valid held high, req1 idle -> 8 consecutive accepts, then 8 consecutive rvalid cycles with the data previously written.
- Reset mid-operation: assert Reset in the cycle after a req0 read accept and at clr_cnt = 300 -> req0_rvalid stays 0; the sweep restarts at address 0; prio = 0.
- Macro off: build without RAM_CLEAR_EN; a req0 write in the first cycle after reset -> accepted immediately; clear_busy is never 1; RAM data survives a later Reset pulse.

Source files
------------

// File: rtl/ram_b_arbiter.sv
// Port-B controller for the shared data RAM: optional zero-fill sweep after reset (compile with
// `define RAM_CLEAR_EN), then round-robin valid/ready arbitration of two requesters.
module ram_b_arbiter #(
    parameter int  DATA_WIDTH         = 16,
    parameter int  RAM_REGISTER_COUNT = 1024,
    localparam int AW                 = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [AW-1:0]         req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [AW-1:0]         req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic [AW-1:0]         ram_address_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_wren_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b,
    output logic                  clear_busy
);

    logic          serve_s;
    logic          clearing_s;
    logic          busy_s;
    logic [AW-1:0] clr_addr_s;
    logic          grant0_s;
    logic          grant1_s;
    logic          prio_q;
    logic          prio_d;
    logic          rvalid0_q;
    logic          rvalid0_d;
    logic          rvalid1_q;
    logic          rvalid1_d;
    logic          rvalid0_s;
    logic          rvalid1_s;

`ifdef RAM_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_REGISTER_COUNT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clr_cnt_q;
    logic [AW-1:0] clr_cnt_d;

    // State register and sweep counter; every reset restarts the sweep at address 0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: leave CLEAR right after the write to the last address
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_SERVE: state_d = ST_SERVE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    assign serve_s    = (state_q == ST_SERVE) && !Reset;
    assign clearing_s = (state_q == ST_CLEAR) && !Reset;
    assign busy_s     = (state_q == ST_CLEAR) || Reset;
    assign clr_addr_s = clr_cnt_q;
`else
    assign serve_s    = !Reset;
    assign clearing_s = 1'b0;
    assign busy_s     = 1'b0;
    assign clr_addr_s = '0;
`endif

    // Round-robin grant: a tie goes to the requester selected by prio
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (serve_s) begin
            if (req0_valid && req1_valid) begin
                grant0_s = !prio_q;
                grant1_s = prio_q;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Priority flips to the other requester after each grant; read responses are queued one cycle
    always_comb begin
        prio_d = prio_q;
        if (grant0_s) begin
            prio_d = 1'b1;
        end else if (grant1_s) begin
            prio_d = 1'b0;
        end else begin
            prio_d = prio_q;
        end
        rvalid0_d = grant0_s && !req0_we;
        rvalid1_d = grant1_s && !req1_we;
    end

    // Priority and response-valid registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // A response registered just before Reset rises must not escape while Reset is high
    assign rvalid0_s = rvalid0_q && !Reset;
    assign rvalid1_s = rvalid1_q && !Reset;

    // Port-B drive, handshakes and read-data steering
    always_comb begin
        ram_wren_b    = 1'b0;
        ram_address_b = '0;
        ram_data_b    = '0;
        if (clearing_s) begin
            ram_wren_b    = 1'b1;
            ram_address_b = clr_addr_s;
        end else if (grant0_s) begin
            ram_wren_b    = req0_we;
            ram_address_b = req0_addr;
            ram_data_b    = req0_wdata;
        end else if (grant1_s) begin
            ram_wren_b    = req1_we;
            ram_address_b = req1_addr;
            ram_data_b    = req1_wdata;
        end else begin
            ram_wren_b    = 1'b0;
            ram_address_b = '0;
            ram_data_b    = '0;
        end
        req0_ready  = grant0_s;
        req1_ready  = grant1_s;
        req0_rvalid = rvalid0_s;
        req1_rvalid = rvalid1_s;
        req0_rdata  = rvalid0_s ? ram_q_b : '0;
        req1_rdata  = rvalid1_s ? ram_q_b : '0;
        clear_busy  = busy_s;
    end

endmodule
